i2c_slave: RTL and testbench
============================

// Module: i2c_slave
// PURPOSE
//  I2C target (responder) for the on-chip i2c_master: 7-bit address match, ACK generation,
//  write-byte receive and read-byte transmit. Oversamples SCL/SDA on the system clock.
//  SDA is open-drain (drive 0 or Z). No clock stretching. Requires clk >= 16x SCL.
// PARAMETERS
//  SLAVE_ADDR  7'h50  7-bit address this target responds to
//  FILT_LEN    3      glitch-filter depth in clk cycles (used only with I2C_GLITCH_FILTER_EN)
// PORTS
//  clk       in     1  system clock, all logic on rising edge
//  rst_n     in     1  synchronous reset, active low
//  scl       in     1  I2C clock from bus
//  sda       inout  1  I2C data; driven 0 when sda_oe=1, else Z
//  tx_data   in     8  byte to send on read; sampled at SCL fall ending the preceding ACK
//  tx_req    out    1  1-clk pulse: next read byte needed, tx_data must be stable by next SCL fall
//  rx_data   out    8  last byte received on write; held until next write byte
//  rx_valid  out    1  1-clk pulse when rx_data updates
//  addressed out    1  high from address ACK until STOP, START or master NACK
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, sda released, rx_data=0, rx_valid=0, tx_req=0,
//   addressed=0, bit counter=0, sync regs preset to 1 (idle bus).
//  Input path: 2-FF synchronizer on scl and sda, then 1 delay reg for edge detect.
//   Pin change -> detected event latency 3 clk.
//  Events: START = sda fall while scl high; STOP = sda rise while scl high;
//   SCL_R / SCL_F = synced scl rise / fall. START/STOP beat SCL edges in same clk.
//  START in any state -> ADDR, counter=0, sda released, addressed=0 (repeated START ok).
//  STOP in any state -> IDLE, sda released, addressed=0.
//  States:
//   IDLE     : sda released; wait for START.
//   ADDR     : shift sda on SCL_R, MSB first, 8 bits (7 addr + R/W). After bit 8:
//              match & R/W=1 -> tx_req pulse. Next SCL_F: match -> drive 0, ADDR_ACK,
//              addressed=1; mismatch -> IDLE (no drive).
//   ADDR_ACK : hold 0 through SCL high. Next SCL_F: R/W=0 -> release, WR_DATA;
//              R/W=1 -> load tx shift reg from tx_data, drive bit7, RD_DATA.
//   WR_DATA  : shift 8 bits on SCL_R. On bit-8 SCL_R: rx_data<=shift, rx_valid pulse.
//              Next SCL_F: drive 0, WR_ACK.
//   WR_ACK   : next SCL_F: release, counter=0, WR_DATA. Target always ACKs write data.
//   RD_DATA  : on each SCL_F drive next bit (sda_oe = ~bit). After bit 0 held a full SCL
//              period, on that SCL_F release -> RD_ACK.
//   RD_ACK   : sample sda on SCL_R. 0 (ACK) -> tx_req pulse; next SCL_F load tx_data,
//              drive bit7, RD_DATA. 1 (NACK) -> release, addressed=0, IDLE.
//  SDA only changes on SCL_F (plus 1 clk), never while scl high, except release on STOP/START.
//  Counter 4 bits, 0..8, reset to 0 on each byte boundary; no wrap.
//  Reset mid-transfer: immediate IDLE, sda released in same cycle; bus recovers at next START.
// CONFIGURATION
//  I2C_GLITCH_FILTER_EN defined: after synchronizer, scl/sda each pass a filter that updates
//   only when input stable FILT_LEN consecutive clk; pulses < FILT_LEN clk ignored;
//   latency becomes 3+FILT_LEN clk.
//  Not defined: no filter, FILT_LEN unused, latency 3 clk.
// TESTING
//  1 Write: START, 0xA0 (0x50,W), 0xA5, STOP -> ACK on addr+data, rx_data=0xA5, one rx_valid,
//    addressed 1 then 0 at STOP.
//  2 Mismatch: START, 0xA2 (0x51,W), 0x11 -> sda never driven, no rx_valid, addressed=0.
//  3 Read: tx_data=0x3C then 0xC3; START, 0xA1, master ACK byte1, NACK byte2 -> bus sees
//    0x3C,0xC3; two tx_req pulses; IDLE after NACK.
//  4 Repeated START: write 0x00 then Sr, 0xA1 read 1 byte tx_data=0x7E -> rx_valid once,
//    read returns 0x7E.
//  5 Reset mid-byte: rst_n low during bit 4 of write -> sda released that clk, all outputs 0;
//    next full write of 0x5A works.
//  6 Filter (macro on, FILT_LEN=3): 2-clk sda low spike while scl high -> no START detected;
//    macro off -> START detected.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, ACK generation, byte receive/transmit, open-drain SDA.
// Define I2C_GLITCH_FILTER_EN to add a FILT_LEN-deep stability filter on synced SCL/SDA.
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    inout  wire        sda_io,
    input  logic [7:0] tx_data_i,
    output logic       tx_req_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       addressed_o
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdAck
    } state_e;

    if (FILT_LEN == 0) begin : g_bad_filt_len
        $error("FILT_LEN must be at least 1");
    end

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_cur, sda_cur;
    logic       scl_prev_q, sda_prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_io};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [CntW-1:0] scl_cnt_q, sda_cnt_q;
    logic            scl_filt_q, sda_filt_q;

    // Output follows the input only after it has differed for FILT_LEN consecutive clocks.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            if (scl_sync_q[1] == scl_filt_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CntW'(FILT_LEN - 1)) begin
                scl_filt_q <= scl_sync_q[1];
                scl_cnt_q  <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + CntW'(1);
            end
            if (sda_sync_q[1] == sda_filt_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CntW'(FILT_LEN - 1)) begin
                sda_filt_q <= sda_sync_q[1];
                sda_cnt_q  <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + CntW'(1);
            end
        end
    end

    assign scl_cur = scl_filt_q;
    assign sda_cur = sda_filt_q;
`else
    assign scl_cur = scl_sync_q[1];
    assign sda_cur = sda_sync_q[1];
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_cur;
            sda_prev_q <= sda_cur;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_cur & ~scl_prev_q;
    assign scl_fall  = ~scl_cur & scl_prev_q;
    assign start_det = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
    assign stop_det  = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [6:0] shift_q;
    logic [6:0] tx_shift_q;
    logic       rw_q, match_q;
    logic       sda_oe_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, tx_req_q, addressed_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            tx_shift_q  <= '0;
            rw_q        <= 1'b0;
            match_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            addressed_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            if (start_det) begin
                state_q     <= StAddr;
                cnt_q       <= '0;
                sda_oe_q    <= 1'b0;
                addressed_q <= 1'b0;
            end else if (stop_det) begin
                state_q     <= StIdle;
                sda_oe_q    <= 1'b0;
                addressed_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: sda_oe_q <= 1'b0;
                    StAddr: begin
                        if (scl_rise && cnt_q < 4'd8) begin
                            shift_q <= {shift_q[5:0], sda_cur};
                            cnt_q   <= cnt_q + 4'd1;
                            if (cnt_q == 4'd7) begin
                                // shift_q holds the 7 address bits; sda_cur is R/W.
                                rw_q     <= sda_cur;
                                match_q  <= (shift_q == SLAVE_ADDR);
                                tx_req_q <= (shift_q == SLAVE_ADDR) && sda_cur;
                            end
                        end else if (scl_fall && cnt_q == 4'd8) begin
                            cnt_q <= '0;
                            if (match_q) begin
                                sda_oe_q    <= 1'b1;
                                addressed_q <= 1'b1;
                                state_q     <= StAddrAck;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            if (rw_q) begin
                                tx_shift_q <= tx_data_i[6:0];
                                sda_oe_q   <= ~tx_data_i[7];
                                cnt_q      <= 4'd1;
                                state_q    <= StRdData;
                            end else begin
                                sda_oe_q <= 1'b0;
                                cnt_q    <= '0;
                                state_q  <= StWrData;
                            end
                        end
                    end
                    StWrData: begin
                        if (scl_rise && cnt_q < 4'd8) begin
                            shift_q <= {shift_q[5:0], sda_cur};
                            cnt_q   <= cnt_q + 4'd1;
                            if (cnt_q == 4'd7) begin
                                rx_data_q  <= {shift_q, sda_cur};
                                rx_valid_q <= 1'b1;
                            end
                        end else if (scl_fall && cnt_q == 4'd8) begin
                            sda_oe_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= StWrAck;
                        end
                    end
                    StWrAck: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            cnt_q    <= '0;
                            state_q  <= StWrData;
                        end
                    end
                    StRdData: begin
                        // cnt_q counts bits already driven; the fall after bit 0 releases.
                        if (scl_fall) begin
                            if (cnt_q == 4'd8) begin
                                sda_oe_q <= 1'b0;
                                cnt_q    <= '0;
                                state_q  <= StRdAck;
                            end else begin
                                sda_oe_q   <= ~tx_shift_q[6];
                                tx_shift_q <= {tx_shift_q[5:0], 1'b0};
                                cnt_q      <= cnt_q + 4'd1;
                            end
                        end
                    end
                    StRdAck: begin
                        if (scl_rise) begin
                            if (sda_cur) begin
                                addressed_q <= 1'b0;
                                state_q     <= StIdle;
                            end else begin
                                tx_req_q <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            tx_shift_q <= tx_data_i[6:0];
                            sda_oe_q   <= ~tx_data_i[7];
                            cnt_q      <= 4'd1;
                            state_q    <= StRdData;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign sda_io      = sda_oe_q ? 1'b0 : 1'bz;
    assign tx_req_o    = tx_req_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign addressed_o = addressed_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, transaction-level expectations, random data.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam logic [6:0] Addr = 7'h50;
    localparam int         Q    = 8;   // quarter SCL period in clk cycles
`ifdef I2C_GLITCH_FILTER_EN
    localparam logic FiltOn = 1'b1;
`else
    localparam logic FiltOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic       tx_req, rx_valid, addressed;
    logic [7:0] rx_data;

    int compared = 0;
    int mismatched = 0;
    int rxv_total = 0;
    int txr_total = 0;
    int drive_total = 0;
    logic [7:0] rx_log[$];

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(Addr), .FILT_LEN(3)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (scl),
        .sda_io     (sda),
        .tx_data_i  (tx_data),
        .tx_req_o   (tx_req),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .addressed_o(addressed)
    );

    // Bus monitor: pulse counts, received-byte log, and target pulling SDA low.
    always @(posedge clk) begin
        #2;
        if (rx_valid) begin
            rxv_total++;
            rx_log.push_back(rx_data);
        end
        if (tx_req) txr_total++;
        if (!m_low && sda === 1'b0) drive_total++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        m_low = ~b;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        s = sda;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic i2c_start();
        m_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        m_low = 1'b1;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        m_low = 1'b0;
        wait_clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack_bit, input logic [7:0] next_tx,
                             output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            d = {d[6:0], s};
        end
        tx_data = next_tx;
        bit_xfer(ack_bit, s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clks(4);
        compared++;
        if (rx_data !== 8'h00) begin
            mismatched++; $display("FAIL reset_rx_data: got %h want 00", rx_data);
        end
        compared++;
        if (rx_valid !== 1'b0) begin
            mismatched++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid);
        end
        compared++;
        if (tx_req !== 1'b0) begin
            mismatched++; $display("FAIL reset_tx_req: got %b want 0", tx_req);
        end
        compared++;
        if (addressed !== 1'b0) begin
            mismatched++; $display("FAIL reset_addressed: got %b want 0", addressed);
        end
        compared++;
        if (sda !== 1'b1) begin
            mismatched++; $display("FAIL reset_sda: got %b want 1", sda);
        end
        rst_n = 1'b1;
        wait_clks(4);
    endtask

    task automatic test_write();
        logic       ack;
        logic [7:0] got;
        int         n, rx_base, v_base;
        logic [7:0] exp_q[$];
        for (int it = 0; it < 4; it++) begin
            exp_q.delete();
            n = (it == 0) ? 1 : int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) exp_q.push_back((it == 0) ? 8'hA5 : 8'($urandom));
            rx_base = rx_log.size();
            v_base  = rxv_total;
            i2c_start();
            send_byte({Addr, 1'b0}, ack);
            compared++;
            if (ack !== 1'b0) begin
                mismatched++; $display("FAIL write_addr_ack: got %b want 0", ack);
            end
            for (int k = 0; k < n; k++) begin
                send_byte(exp_q[k], ack);
                compared++;
                if (ack !== 1'b0) begin
                    mismatched++; $display("FAIL write_data_ack[%0d]: got %b want 0", k, ack);
                end
            end
            compared++;
            if (addressed !== 1'b1) begin
                mismatched++; $display("FAIL write_addressed: got %b want 1", addressed);
            end
            i2c_stop();
            wait_clks(4);
            compared++;
            if (addressed !== 1'b0) begin
                mismatched++; $display("FAIL write_addressed_stop: got %b want 0", addressed);
            end
            compared++;
            if (rxv_total - v_base != n) begin
                mismatched++;
                $display("FAIL write_rx_valid_count: got %0d want %0d", rxv_total - v_base, n);
            end
            for (int k = 0; k < n; k++) begin
                got = (rx_base + k < rx_log.size()) ? rx_log[rx_base + k] : 8'hxx;
                compared++;
                if (got !== exp_q[k]) begin
                    mismatched++;
                    $display("FAIL write_rx_byte[%0d]: got %h want %h", k, got, exp_q[k]);
                end
            end
            compared++;
            if (rx_data !== exp_q[n-1]) begin
                mismatched++; $display("FAIL write_rx_hold: got %h want %h", rx_data, exp_q[n-1]);
            end
        end
    endtask

    task automatic test_mismatch();
        logic       ack;
        logic [6:0] a;
        logic [7:0] d;
        int         v_base, drv_base;
        for (int it = 0; it < 4; it++) begin
            a = 7'h51;
            if (it != 0) begin
                do a = 7'($urandom); while (a == Addr);
            end
            d = (it == 0) ? 8'h11 : 8'($urandom);
            v_base   = rxv_total;
            drv_base = drive_total;
            i2c_start();
            send_byte({a, (it == 0) ? 1'b0 : 1'($urandom)}, ack);
            compared++;
            if (ack !== 1'b1) begin
                mismatched++; $display("FAIL mismatch_addr_nack[%h]: got %b want 1", a, ack);
            end
            send_byte(d, ack);
            compared++;
            if (ack !== 1'b1) begin
                mismatched++; $display("FAIL mismatch_data_nack: got %b want 1", ack);
            end
            compared++;
            if (addressed !== 1'b0) begin
                mismatched++; $display("FAIL mismatch_addressed: got %b want 0", addressed);
            end
            i2c_stop();
            wait_clks(4);
            compared++;
            if (drive_total != drv_base) begin
                mismatched++;
                $display("FAIL mismatch_sda_driven: got %0d want 0", drive_total - drv_base);
            end
            compared++;
            if (rxv_total != v_base) begin
                mismatched++;
                $display("FAIL mismatch_rx_valid: got %0d want 0", rxv_total - v_base);
            end
        end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        int         n, t_base;
        logic [7:0] bytes_q[$];
        for (int it = 0; it < 3; it++) begin
            bytes_q.delete();
            if (it == 0) begin
                bytes_q.push_back(8'h3C);
                bytes_q.push_back(8'hC3);
            end else begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) bytes_q.push_back(8'($urandom));
            end
            n       = bytes_q.size();
            t_base  = txr_total;
            tx_data = bytes_q[0];
            i2c_start();
            send_byte({Addr, 1'b1}, ack);
            compared++;
            if (ack !== 1'b0) begin
                mismatched++; $display("FAIL read_addr_ack: got %b want 0", ack);
            end
            for (int k = 0; k < n; k++) begin
                recv_byte((k == n - 1), (k + 1 < n) ? bytes_q[k+1] : 8'($urandom), d);
                compared++;
                if (d !== bytes_q[k]) begin
                    mismatched++; $display("FAIL read_byte[%0d]: got %h want %h", k, d, bytes_q[k]);
                end
            end
            compared++;
            if (addressed !== 1'b0) begin
                mismatched++; $display("FAIL read_addressed_nack: got %b want 0", addressed);
            end
            compared++;
            if (txr_total - t_base != n) begin
                mismatched++;
                $display("FAIL read_tx_req_count: got %0d want %0d", txr_total - t_base, n);
            end
            i2c_stop();
            wait_clks(4);
        end
    endtask

    task automatic test_back_to_back();
        logic       ack;
        logic [7:0] d, got;
        int         v_base, rx_base;
        v_base  = rxv_total;
        rx_base = rx_log.size();
        i2c_start();
        send_byte({Addr, 1'b0}, ack);
        send_byte(8'h00, ack);
        compared++;
        if (ack !== 1'b0) begin
            mismatched++; $display("FAIL rstart_write_ack: got %b want 0", ack);
        end
        tx_data = 8'h7E;
        i2c_start();
        send_byte({Addr, 1'b1}, ack);
        compared++;
        if (ack !== 1'b0) begin
            mismatched++; $display("FAIL rstart_read_addr_ack: got %b want 0", ack);
        end
        recv_byte(1'b1, 8'h00, d);
        compared++;
        if (d !== 8'h7E) begin
            mismatched++; $display("FAIL rstart_read_byte: got %h want 7e", d);
        end
        i2c_stop();
        wait_clks(4);
        compared++;
        if (rxv_total - v_base != 1) begin
            mismatched++; $display("FAIL rstart_rx_valid: got %0d want 1", rxv_total - v_base);
        end
        got = (rx_base < rx_log.size()) ? rx_log[rx_base] : 8'hxx;
        compared++;
        if (got !== 8'h00) begin
            mismatched++; $display("FAIL rstart_rx_byte: got %h want 00", got);
        end
    endtask

    task automatic test_reset_mid();
        logic       s, ack;
        logic [7:0] b;
        // Reset while the target is driving the address ACK.
        b = {Addr, 1'b0};
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        m_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(2);
        compared++;
        if (sda !== 1'b0) begin
            mismatched++; $display("FAIL midrst_ack_driven: got %b want 0", sda);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if (sda !== 1'b1) begin
            mismatched++; $display("FAIL midrst_sda_release: got %b want 1", sda);
        end
        compared++;
        if (addressed !== 1'b0 || rx_data !== 8'h00 || rx_valid !== 1'b0 || tx_req !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_outputs: got %b/%h/%b/%b want 0/00/0/0",
                     addressed, rx_data, rx_valid, tx_req);
        end
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
        // Reset during bit 4 of a write data byte.
        b = 8'h5A;
        i2c_start();
        send_byte({Addr, 1'b0}, ack);
        for (int i = 7; i >= 5; i--) bit_xfer(b[i], s);
        m_low = ~b[4];
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(2);
        rst_n = 1'b0;
        wait_clks(2);
        compared++;
        if (addressed !== 1'b0 || rx_data !== 8'h00 || sda !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst_bit4: got %b/%h/%b want 0/00/1", addressed, rx_data, sda);
        end
        rst_n = 1'b1;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
        i2c_start();
        send_byte({Addr, 1'b0}, ack);
        compared++;
        if (ack !== 1'b0) begin
            mismatched++; $display("FAIL midrst_recover_ack: got %b want 0", ack);
        end
        send_byte(8'h5A, ack);
        compared++;
        if (rx_data !== 8'h5A || ack !== 1'b0) begin
            mismatched++; $display("FAIL midrst_recover_rx: got %h/%b want 5a/0", rx_data, ack);
        end
        i2c_stop();
        wait_clks(4);
    endtask

    task automatic test_spike();
        logic ack, s;
        int   v_base;
        i2c_start();
        send_byte({Addr, 1'b0}, ack);
        v_base = rxv_total;
        // 2-clk SDA low pulse during a high data bit: a START+STOP unless filtered.
        m_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(2);
        m_low = 1'b1;
        wait_clks(2);
        m_low = 1'b0;
        wait_clks(Q);
        compared++;
        if (addressed !== FiltOn) begin
            mismatched++; $display("FAIL spike_addressed: got %b want %b", addressed, FiltOn);
        end
        scl = 1'b0;
        wait_clks(Q);
        for (int i = 0; i < 7; i++) bit_xfer(1'b1, s);
        bit_xfer(1'b1, ack);
        compared++;
        if (ack !== ~FiltOn) begin
            mismatched++; $display("FAIL spike_data_ack: got %b want %b", ack, ~FiltOn);
        end
        compared++;
        if (rxv_total - v_base != (FiltOn ? 1 : 0)) begin
            mismatched++;
            $display("FAIL spike_rx_valid: got %0d want %0d", rxv_total - v_base, FiltOn ? 1 : 0);
        end
        i2c_stop();
        wait_clks(4);
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_spike();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
